// File: rtl/tc_pkg.sv
// -----------------------------------------------------------------------------
// tc_pkg -- shared definitions for the multi-channel timer/counter (tc_multi).
//
// Contents:
//   tc_state_e      per-channel FSM state (IDLE, LOAD, CNT, INT)
//   OFF_*           register word offsets inside a channel's 16-byte window
//   CTRL_*          bit positions inside the CTRL register
//   ch_bits()       width of the channel-index field of the word address
// -----------------------------------------------------------------------------
package tc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_MODE      = 1;
  localparam int CTRL_IM        = 3;
  localparam int CTRL_CASC      = 4;
  localparam int CTRL_PRESC_LSB = 8;

  // A single channel still gets a one-bit index so the decode stays uniform.
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tc_channel.sv
// -----------------------------------------------------------------------------
// tc_channel -- one timer channel: CTRL/PRESET/COUNT/STATUS registers,
// IDLE/LOAD/CNT/INT state machine, prescaler and sticky interrupt pending.
//
// Parameters:
//   CNT_W    counter/preset width (8..32)
//   PRE_W    prescaler field width
//   CASC_OK  1: the CASC bit is implemented and selects casc_in as tick source
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   we       write strobe, already qualified with this channel's index
//   offset   register word offset within the channel window
//   din      write data
//   casc_in  one-cycle INT-entry pulse from the previous channel
//   rdata    combinational read data of the register selected by offset
//   irq      pend & IM
//   int_evt  high for the single cycle the channel spends in INT
// -----------------------------------------------------------------------------
module tc_channel
  import tc_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int PRE_W   = 8,
  parameter bit CASC_OK = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [1:0]  offset,
  input  logic [31:0] din,
  input  logic        casc_in,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        int_evt
);

  tc_state_e          state;
  logic               en;
  logic               mode;
  logic               im;
  logic               casc;
  logic               pend;
  logic [PRE_W-1:0]   presc;
  logic [PRE_W-1:0]   pcnt;
  logic [CNT_W-1:0]   preset;
  logic [CNT_W-1:0]   count;

  logic wr_ctrl;
  logic wr_preset;
  logic wr_status;
  logic en_nxt;
  logic use_casc;
  logic pre_hit;
  logic tick;

  assign wr_ctrl   = we && (offset == OFF_CTRL);
  assign wr_preset = we && (offset == OFF_PRESET);
  assign wr_status = we && (offset == OFF_STATUS);

  // IDLE looks at the value EN takes at this edge so that LOAD follows the
  // enabling write directly.
  assign en_nxt   = wr_ctrl ? din[CTRL_EN] : en;
  assign use_casc = CASC_OK && casc;

  // >= rather than == so that lowering PRESC below the running prescale
  // count mid-period does not cost a full wrap of the counter.
  assign pre_hit = (pcnt >= presc);
  assign tick    = use_casc ? casc_in : pre_hit;

  assign irq     = pend & im;
  assign int_evt = (state == ST_INT);

  // NOTE: all state here is updated with non-blocking assignments so every
  // branch reads the pre-edge values; later assignments in the block (pend
  // set after the STATUS clear) deliberately override earlier ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      en     <= 1'b0;
      mode   <= 1'b0;
      im     <= 1'b0;
      casc   <= 1'b0;
      pend   <= 1'b0;
      presc  <= '0;
      pcnt   <= '0;
      preset <= '0;
      count  <= '0;
    end else begin
      if (wr_ctrl) begin
        en    <= din[CTRL_EN];
        mode  <= din[CTRL_MODE];
        im    <= din[CTRL_IM];
        casc  <= CASC_OK ? din[CTRL_CASC] : 1'b0;
        presc <= din[CTRL_PRESC_LSB +: PRE_W];
      end

      if (wr_preset) begin
        preset <= din[CNT_W-1:0];
      end

      if (wr_status && din[0]) begin
        pend <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (en_nxt) begin
            state <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          count <= preset;
          pcnt  <= '0;
          state <= ST_CNT;
        end

        ST_CNT: begin
          if (!en) begin
            state <= ST_IDLE;
          end else begin
            if (!use_casc) begin
              pcnt <= pre_hit ? '0 : pcnt + PRE_W'(1);
            end
            if (tick) begin
              // COUNT of 0 or 1 both finish on this tick, so PRESET=0
              // behaves like PRESET=1.
              if (count > CNT_W'(1)) begin
                count <= count - CNT_W'(1);
              end else begin
                count <= '0;
                pend  <= 1'b1;
                state <= ST_INT;
              end
            end
          end
        end

        ST_INT: begin
          if (mode) begin
            state <= ST_LOAD;
          end else begin
            // A CTRL write on this same edge has already decided EN.
            if (!wr_ctrl) begin
              en <= 1'b0;
            end
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: rdata gets a default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    rdata = '0;
    case (offset)
      OFF_CTRL: begin
        rdata[CTRL_EN]                   = en;
        rdata[CTRL_MODE]                 = mode;
        rdata[CTRL_IM]                   = im;
        rdata[CTRL_CASC]                 = casc;
        rdata[CTRL_PRESC_LSB +: PRE_W]   = presc;
      end
      OFF_PRESET: rdata[CNT_W-1:0] = preset;
      OFF_COUNT:  rdata[CNT_W-1:0] = count;
      OFF_STATUS: rdata[0]         = pend;
      default:    rdata            = '0;
    endcase
  end

  // Write-data bits outside the implemented fields are intentionally dropped.
  logic unused_din;
  assign unused_din = ^din;

endmodule

// File: rtl/tc_multi.sv
// -----------------------------------------------------------------------------
// tc_multi -- NUM_CH independent down-counting timers behind one word-
// addressed register window (4 words / 16 bytes per channel).
//
// Optional feature: define TC_CASCADE_EN to let channel i>0 count INT events
// of channel i-1 (CTRL.CASC=1). Without it CASC is not stored and reads 0.
//
// Parameters:
//   NUM_CH   number of channels (1..8)
//   CNT_W    counter/preset width (8..32)
//   PRE_W    prescaler field width
//
// Ports:
//   clk      system clock
//   reset    asynchronous active-low reset
//   Addr     word address [31:2]; channel = Addr[CH_BITS+3:4], word = Addr[3:2]
//   WE       write enable
//   Din      write data
//   Dout     combinational read data (0 for channel index >= NUM_CH)
//   IRQ      per-channel interrupt (pend & IM)
//   IRQ_any  OR of IRQ
// -----------------------------------------------------------------------------
module tc_multi
  import tc_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:2]       Addr,
  input  logic              WE,
  input  logic [31:0]       Din,
  output logic [31:0]       Dout,
  output logic [NUM_CH-1:0] IRQ,
  output logic              IRQ_any
);

  localparam int CH_BITS = ch_bits(NUM_CH);

`ifdef TC_CASCADE_EN
  localparam bit CASC_EN = 1'b1;
`else
  localparam bit CASC_EN = 1'b0;
`endif

  logic [CH_BITS-1:0] ch_idx;
  logic [1:0]         offset;
  logic [31:0]        rdata [NUM_CH];
  logic [NUM_CH-1:0]  int_evt;
  logic [NUM_CH-1:0]  casc_in;

  assign ch_idx = Addr[CH_BITS+3:4];
  assign offset = Addr[3:2];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    if (gi == 0) begin : g_first
      assign casc_in[gi] = 1'b0;
    end else begin : g_chain
      assign casc_in[gi] = int_evt[gi-1];
    end

    tc_channel #(
      .CNT_W   (CNT_W),
      .PRE_W   (PRE_W),
      .CASC_OK (CASC_EN && (gi > 0))
    ) u_ch (
      .clk     (clk),
      .rst_n   (reset),
      .we      (WE && (ch_idx == CH_BITS'(gi))),
      .offset  (offset),
      .din     (Din),
      .casc_in (casc_in[gi]),
      .rdata   (rdata[gi]),
      .irq     (IRQ[gi]),
      .int_evt (int_evt[gi])
    );
  end

  // Indices with no matching channel fall through to the zero default.
  always_comb begin
    Dout = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == CH_BITS'(i)) begin
        Dout = rdata[i];
      end
    end
  end

  assign IRQ_any = |IRQ;

  // Upper address bits are decoded by the Bridge; the last channel's INT
  // event has no successor to cascade into.
  logic unused_top;
  assign unused_top = ^{Addr[31:CH_BITS+4], int_evt[NUM_CH-1]};

endmodule

// File: tb/tb_tc_multi.sv
// -----------------------------------------------------------------------------
// tb_tc_multi -- directed self-checking bench for tc_multi.
// u_dut:   default build (NUM_CH=2, CNT_W=32, PRE_W=8)
// u_dut16: NUM_CH=1, CNT_W=16 for truncation and out-of-range index checks
// -----------------------------------------------------------------------------
module tb_tc_multi;

  logic        clk;
  logic        reset;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic [1:0]  IRQ;
  logic        IRQ_any;

  logic [31:2] a16;
  logic        we16;
  logic [31:0] din16;
  logic [31:0] dout16;
  logic [0:0]  irq16;
  logic        irq_any16;

  int n_checks = 0;
  int n_fail   = 0;

  tc_multi #(.NUM_CH(2), .CNT_W(32), .PRE_W(8)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .IRQ     (IRQ),
    .IRQ_any (IRQ_any)
  );

  tc_multi #(.NUM_CH(1), .CNT_W(16), .PRE_W(8)) u_dut16 (
    .clk     (clk),
    .reset   (reset),
    .Addr    (a16),
    .WE      (we16),
    .Din     (din16),
    .Dout    (dout16),
    .IRQ     (irq16),
    .IRQ_any (irq_any16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:2] waddr(input int ch, input int off);
    return 30'(ch * 4 + off);
  endfunction

  // One write on the next rising edge; returns 1 ns after that edge.
  task automatic wr(input int ch, input int off, input logic [31:0] d);
    @(negedge clk);
    Addr = waddr(ch, off);
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic rd(input int ch, input int off, output logic [31:0] d);
    Addr = waddr(ch, off);
    #1;
    d = Dout;
  endtask

  task automatic wr16(input int ch, input int off, input logic [31:0] d);
    @(negedge clk);
    a16   = waddr(ch, off);
    din16 = d;
    we16  = 1'b1;
    @(posedge clk);
    #1;
    we16 = 1'b0;
  endtask

  task automatic rd16(input int ch, input int off, output logic [31:0] d);
    a16 = waddr(ch, off);
    #1;
    d = dout16;
  endtask

  logic [31:0] v;

  initial begin
    reset = 1'b0;
    Addr  = '0;
    WE    = 1'b0;
    Din   = '0;
    a16   = '0;
    we16  = 1'b0;
    din16 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // ---- asynchronous reset in the middle of a count ----
    wr(0, 1, 32'd100);
    wr(0, 0, 32'h9);
    repeat (3) @(posedge clk);
    #1;
    rd(0, 2, v);
    check("pre_reset_count_running", 32'(v != 0), 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_count", Dout, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int ch = 0; ch < 2; ch++) begin
      for (int off = 0; off < 4; off++) begin
        rd(ch, off, v);
        check($sformatf("reset_reg_ch%0d_w%0d", ch, off), v, 32'd0);
      end
    end
    check("reset_irq", 32'(IRQ), 32'd0);
    check("reset_irq_any", 32'(IRQ_any), 32'd0);

    // ---- one-shot, PRESET=5, PRESC=0 ----
    wr(0, 1, 32'd5);
    wr(0, 0, 32'h9);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      rd(0, 2, v);
      check($sformatf("oneshot_count_e%0d", k), v, 32'(6 - k));
      check($sformatf("oneshot_irq_e%0d", k), 32'(IRQ[0]), 32'(k == 6));
    end
    @(posedge clk);
    #1;
    rd(0, 0, v);
    check("oneshot_ctrl_en_cleared", v, 32'h8);
    wr(0, 3, 32'd0);
    rd(0, 3, v);
    check("status_write0_keeps", v, 32'd1);
    wr(0, 3, 32'd1);
    rd(0, 3, v);
    check("status_write1_clears", v, 32'd0);
    check("oneshot_irq_cleared", 32'(IRQ[0]), 32'd0);

    // ---- auto-reload with PRESC=3 on channel 1 ----
    wr(1, 1, 32'd3);
    wr(1, 0, 32'h30B);
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      if (c == 20) begin
        Addr = waddr(1, 3);
        Din  = 32'd1;
        WE   = 1'b1;
      end
      @(posedge clk);
      #1;
      WE = 1'b0;
      rd(1, 2, v);
      case (c)
        4:  check("reload_count_c4", v, 32'd3);
        5:  check("reload_count_c5", v, 32'd2);
        12: begin
          check("reload_count_c12", v, 32'd1);
          check("reload_irq_any_c12", 32'(IRQ_any), 32'd0);
        end
        13: begin
          check("reload_count_c13", v, 32'd0);
          check("reload_irq1_c13", 32'(IRQ[1]), 32'd1);
          check("reload_irq_any_c13", 32'(IRQ_any), 32'd1);
        end
        15: check("reload_count_c15", v, 32'd3);
        19: check("reload_count_c19", v, 32'd2);
        20: check("reload_irq1_cleared_c20", 32'(IRQ[1]), 32'd0);
        26: check("reload_irq1_c26", 32'(IRQ[1]), 32'd0);
        27: check("reload_irq1_c27", 32'(IRQ[1]), 32'd1);
        default: ;
      endcase
    end
    wr(1, 0, 32'h0);
    wr(1, 3, 32'd1);

    // ---- masked events and clear/set collision on channel 0 ----
    wr(0, 1, 32'd2);
    wr(0, 0, 32'h3);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 5 || c == 7) begin
        Addr = waddr(0, 3);
        Din  = 32'd1;
        WE   = 1'b1;
      end
      @(posedge clk);
      #1;
      WE = 1'b0;
      rd(0, 3, v);
      case (c)
        3: begin
          check("masked_pend_c3", v, 32'd1);
          check("masked_irq_c3", 32'(IRQ[0]), 32'd0);
        end
        5: check("clear_pend_c5", v, 32'd0);
        7: check("collision_set_wins_c7", v, 32'd1);
        default: ;
      endcase
    end
    wr(0, 0, 32'h0);
    wr(0, 3, 32'd1);

    // ---- PRESET=0 finishes after a single tick ----
    wr(0, 1, 32'd0);
    wr(0, 0, 32'h9);
    @(posedge clk);
    #1;
    check("preset0_irq_e1", 32'(IRQ[0]), 32'd0);
    @(posedge clk);
    #1;
    check("preset0_irq_e2", 32'(IRQ[0]), 32'd1);
    wr(0, 3, 32'd1);

    // ---- COUNT is read-only ----
    wr(0, 1, 32'd7);
    wr(0, 2, 32'hAA);
    rd(0, 2, v);
    check("count_write_ignored", v, 32'd0);
    rd(0, 1, v);
    check("count_write_preset_intact", v, 32'd7);

    // ---- EN=0 mid-count stops and holds COUNT ----
    wr(0, 1, 32'd10);
    wr(0, 0, 32'h1);
    repeat (2) @(posedge clk);
    wr(0, 0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rd(0, 2, v);
    check("stop_count_holds", v, 32'd8);

    // ---- CNT_W=16 truncation and channel index == NUM_CH ----
    wr16(0, 1, 32'h12345);
    rd16(0, 1, v);
    check("cnt16_preset_trunc", v, 32'h2345);
    wr16(1, 0, 32'hFFFF_FFFF);
    wr16(1, 1, 32'h5555);
    rd16(1, 0, v);
    check("oob_ctrl_reads0", v, 32'd0);
    rd16(1, 1, v);
    check("oob_preset_reads0", v, 32'd0);
    rd16(0, 0, v);
    check("oob_no_alias_ctrl", v, 32'd0);
    rd16(0, 1, v);
    check("oob_no_alias_preset", v, 32'h2345);
    check("oob_irq16", 32'(irq16), 32'd0);

    // ---- CASC bit ----
    wr(0, 0, 32'h10);
    rd(0, 0, v);
    check("ch0_casc_reads0", v, 32'd0);
`ifdef TC_CASCADE_EN
    wr(1, 1, 32'd3);
    wr(1, 0, 32'h19);
    rd(1, 0, v);
    check("ch1_casc_reads1", v, 32'h19);
    wr(0, 1, 32'd2);
    wr(0, 0, 32'h3);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      rd(1, 2, v);
      case (c)
        3:  check("casc_ch1_count_c3", v, 32'd3);
        4:  check("casc_ch1_count_c4", v, 32'd2);
        11: check("casc_ch1_irq_c11", 32'(IRQ[1]), 32'd0);
        12: check("casc_ch1_irq_c12", 32'(IRQ[1]), 32'd1);
        default: ;
      endcase
    end
`else
    wr(1, 0, 32'h10);
    rd(1, 0, v);
    check("ch1_casc_absent_reads0", v, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tc_multi.md
Name: tc_multi

Overview:
- Parametrised multi-channel timer/counter; successor to the two fixed single-channel timers on the CPU bridge.
- NUM_CH independent down-counters behind one word-addressed register window.
- Per channel: mode (one-shot / auto-reload), clock prescaler, sticky interrupt pending with mask.
- Sits behind the Bridge; exposes a per-channel IRQ vector for the CPU HWInt inputs.

Parameters:
NUM_CH, 2, number of timer channels (1..8)
CNT_W, 32, counter/preset width in bits (8..32); narrower values are zero-extended on read, truncated on write
PRE_W, 8, prescaler field width; one count tick every (PRESC+1) clocks

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
Addr  in  30  word address [31:2]; only Addr[CH_BITS+3:2] decoded, upper bits ignored (Bridge decodes base)
WE  in  1  write enable for the addressed register
Din  in  32  write data
Dout  out  32  combinational read data of addressed register
IRQ  out  NUM_CH  per-channel interrupt = pend & IM
IRQ_any  out  1  OR of IRQ

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low.
- Register map: per channel 4 words, stride 16 B, channel index = Addr[CH_BITS+3:4], CH_BITS=clog2(NUM_CH) (min 1).
  - word 0 CTRL: [0] EN, [1] MODE (0 one-shot, 1 auto-reload), [3] IM, [4] CASC (optional feature), [8+PRE_W-1:8] PRESC, other bits read 0.
  - word 1 PRESET: R/W.
  - word 2 COUNT: read-only, writes ignored.
  - word 3 STATUS: [0] pend; write 1 to bit 0 clears it, write 0 has no effect.
- Channel index >= NUM_CH: writes ignored, reads 0.
- Reset: all registers, COUNT, prescale counters, pend = 0; FSM = IDLE; IRQ = 0, IRQ_any = 0.
- Per-channel FSM (IDLE, LOAD, CNT, INT):
  - IDLE: EN=1 -> LOAD.
  - LOAD: COUNT <= PRESET, prescale counter <= 0 -> CNT.
  - CNT: EN=0 -> IDLE (COUNT holds). On a tick: COUNT>1 -> COUNT-1; otherwise COUNT <= 0, pend <= 1, -> INT.
  - INT: MODE=0 -> EN cleared, -> IDLE. MODE=1 -> LOAD.
- Tick generation: prescale counter increments each clock in CNT; tick when it equals PRESC, then wraps to 0. PRESC=0 gives a tick every clock.
- Latency, PRESC=0, PRESET=N>=1: EN write at edge e; LOAD at e+1; pend set at edge e+1+N; IRQ visible next cycle.
- PRESET=0 behaves as PRESET=1 (one tick to INT).
- PRESET write during CNT affects the next LOAD only.
- CTRL write during CNT: new PRESC/MODE take effect immediately; EN=0 stops at next edge.
- Simultaneous pend set (INT event) and STATUS clear in the same cycle: set wins.
- pend is sticky in both modes; IM=0 masks IRQ only, pend still records the event.
- Dout depends only on Addr and current state; a write is not visible on Dout until after the edge.
- Asynchronous reset mid-count aborts immediately to reset values.

Optional Feature:
- Macro TC_CASCADE_EN.
- Defined: for channel i>0, CTRL.CASC=1 makes the channel tick on each INT entry of channel i-1 instead of the prescaler (PRESC ignored). CASC is R/W for i>0; channel 0 CASC reads 0.
- Undefined: CASC bit not stored, reads 0, writes ignored; all channels use the prescaler.

Decomposition:
- Package tc_pkg:
  - FSM state enum (IDLE, LOAD, CNT, INT)
  - register word offsets (CTRL=0, PRESET=1, COUNT=2, STATUS=3)
  - CTRL bit positions (EN, MODE, IM, CASC, PRESC_LSB)
- Sub-module tc_channel: one channel's registers, FSM, prescaler and pend. Inputs: decoded per-channel WE/offset/Din and cascade-in; outputs: read data, irq, INT-event.
- tc_multi: generate-loop of NUM_CH instances, address decode, Dout mux, IRQ_any OR.

Test Plan:
- Reset: hold reset=0 mid-count, release -> all registers read 0, IRQ=0, FSM IDLE.
- One-shot: ch0 PRESET=5, CTRL=0x9 (EN, IM, MODE 0, PRESC 0) -> COUNT reads 5,4,3,2,1,0; IRQ[0]=1 exactly 6 cycles after the CTRL write edge; CTRL.EN reads 0 afterward; STATUS write 1 -> IRQ[0]=0.
- Auto-reload with prescaler: ch1 PRESET=3, CTRL=0x30B (EN, MODE 1, IM, PRESC 3) -> COUNT decrements every 4 clocks; pend sets every 4*3+2=14 cycles; IRQ_any=1 from the first event.
- Masking and collision: IM=0 event -> STATUS=1, IRQ=0. STATUS clear on the same edge as a new event -> pend stays 1.
- Boundaries: PRESET=0 -> INT after one tick. Access to channel index NUM_CH -> Dout=0, no state change. COUNT write ignored. CNT_W=16: Din=0x12345 into PRESET reads back 0x2345.
- TC_CASCADE_EN: ch0 PRESET=2 auto-reload, ch1 PRESET=3 CASC=1 -> ch1 pend sets after ch0's 3rd INT event. Without the macro, CASC reads 0.
